// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared state type, default widths and fixed-point constants
package mandel_pkg;

   // Default datapath geometry: signed fixed point with FRAC fraction bits.
   localparam int DEF_W      = 27;
   localparam int DEF_FRAC   = 23;
   localparam int DEF_ITER_W = 32;
   localparam int DEF_DIM_W  = 10;

   // Scan controller states.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ITER = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // 4.0 in the default DEF_W / DEF_FRAC format (the escape radius squared).
   localparam logic signed [DEF_W-1:0] FOUR = DEF_W'(4 << DEF_FRAC);

endpackage

// File: rtl/mandel_step.sv
// rtl/mandel_step.sv - one combinational z = z^2 + c step with escape test
module mandel_step
   import mandel_pkg::*;
#(
   parameter int W    = DEF_W,
   parameter int FRAC = DEF_FRAC
) (
   input  logic signed [W-1:0] zr,
   input  logic signed [W-1:0] zi,
   input  logic signed [W-1:0] cr,
   input  logic signed [W-1:0] ci,
   output logic signed [W-1:0] zr_next,
   output logic signed [W-1:0] zi_next,
   output logic                escape
);

   // Products and the magnitude are held at 2W+1 bits so nothing is lost
   // before the escape compare; the compare limit carries 2*FRAC fraction bits.
   localparam int PW = 2 * W + 1;
   localparam logic signed [PW-1:0] ESC_LIMIT = PW'(FOUR) <<< FRAC;

   logic signed [PW-1:0] zr_x;
   logic signed [PW-1:0] zi_x;
   logic signed [PW-1:0] zr_sq;
   logic signed [PW-1:0] zi_sq;
   logic signed [PW-1:0] zrzi_2;
   logic signed [PW-1:0] mag_sq;
   logic signed [W-1:0]  zr_sq_t;
   logic signed [W-1:0]  zi_sq_t;
   logic signed [W-1:0]  zrzi_2_t;

   assign zr_x = {{(W + 1){zr[W-1]}}, zr};
   assign zi_x = {{(W + 1){zi[W-1]}}, zi};

   assign zr_sq  = zr_x * zr_x;
   assign zi_sq  = zi_x * zi_x;
   assign zrzi_2 = (zr_x * zi_x) <<< 1;

   // Escape test on the current z at full precision.
   assign mag_sq = zr_sq + zi_sq;
   assign escape = (mag_sq > ESC_LIMIT);

   // Rescale products back to FRAC fraction bits, truncate to W; sums wrap.
   assign zr_sq_t  = W'(zr_sq >>> FRAC);
   assign zi_sq_t  = W'(zi_sq >>> FRAC);
   assign zrzi_2_t = W'(zrzi_2 >>> FRAC);

   assign zr_next = zr_sq_t - zi_sq_t + cr;
   assign zi_next = zrzi_2_t + ci;

endmodule

// File: rtl/mandel_scan_iterator.sv
// rtl/mandel_scan_iterator.sv - row-major Mandelbrot grid scanner with valid/ready result port
module mandel_scan_iterator
   import mandel_pkg::*;
#(
   parameter int W      = DEF_W,
   parameter int FRAC   = DEF_FRAC,
   parameter int ITER_W = DEF_ITER_W,
   parameter int DIM_W  = DEF_DIM_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [W-1:0] cr_start,
   input  logic signed [W-1:0] ci_start,
   input  logic signed [W-1:0] cr_step,
   input  logic signed [W-1:0] ci_step,
   input  logic [DIM_W-1:0]    num_cols,
   input  logic [DIM_W-1:0]    num_rows,
   input  logic [ITER_W-1:0]   max_iterations,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ITER_W-1:0]   out_iterations,
   output logic                out_escaped,
   output logic [DIM_W-1:0]    out_col,
   output logic [DIM_W-1:0]    out_row,
   output logic signed [W-1:0] out_zr,
   output logic signed [W-1:0] out_zi,
   output logic                busy,
   output logic                all_done
);

   state_t state;
   state_t next_state;

   // Scan parameters captured on an accepted start.
   logic signed [W-1:0] cr_start_q;
   logic signed [W-1:0] cr_step_q;
   logic signed [W-1:0] ci_step_q;
   logic [DIM_W-1:0]    num_cols_q;
   logic [DIM_W-1:0]    num_rows_q;
   logic [ITER_W-1:0]   max_q;

   // Current pixel position and its c value.
   logic [DIM_W-1:0]    col;
   logic [DIM_W-1:0]    row;
   logic signed [W-1:0] cr_pix;
   logic signed [W-1:0] ci_pix;

   // Iteration state for the pixel in flight.
   logic signed [W-1:0] zr;
   logic signed [W-1:0] zi;
   logic [ITER_W-1:0]   iter;
   logic                esc_q;

   logic signed [W-1:0] zr_next;
   logic signed [W-1:0] zi_next;
   logic                escape;

   logic dims_empty;
   logic iter_at_max;
   logic col_last;
   logic row_last;
   logic last_pix;

   assign dims_empty  = (num_cols == '0) || (num_rows == '0);
   assign iter_at_max = (iter == max_q);
   assign col_last    = (col == num_cols_q - DIM_W'(1));
   assign row_last    = (row == num_rows_q - DIM_W'(1));
   assign last_pix    = col_last && row_last;

   mandel_step #(
      .W    (W),
      .FRAC (FRAC)
   ) u_step (
      .zr      (zr),
      .zi      (zi),
      .cr      (cr_pix),
      .ci      (ci_pix),
      .zr_next (zr_next),
      .zi_next (zi_next),
      .escape  (escape)
   );

   // State register; reset drops straight back to IDLE at any point in a scan.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus the state-derived status outputs.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      all_done   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = dims_empty ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            busy       = 1'b1;
            next_state = S_ITER;
         end
         S_ITER: begin
            busy = 1'b1;
            if (escape || iter_at_max) begin
               next_state = S_EMIT;
            end
         end
         S_EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               next_state = last_pix ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            all_done = 1'b1;
            if (start) begin
               next_state = dims_empty ? S_DONE : S_LOAD;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Operand capture, per-pixel iteration and scan-position advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cr_start_q <= '0;
         cr_step_q  <= '0;
         ci_step_q  <= '0;
         num_cols_q <= '0;
         num_rows_q <= '0;
         max_q      <= '0;
         col        <= '0;
         row        <= '0;
         cr_pix     <= '0;
         ci_pix     <= '0;
         zr         <= '0;
         zi         <= '0;
         iter       <= '0;
         esc_q      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  cr_start_q <= cr_start;
                  cr_step_q  <= cr_step;
                  ci_step_q  <= ci_step;
                  num_cols_q <= num_cols;
                  num_rows_q <= num_rows;
                  max_q      <= max_iterations;
                  col        <= '0;
                  row        <= '0;
                  cr_pix     <= cr_start;
                  ci_pix     <= ci_start;
               end
            end
            S_LOAD: begin
               zr    <= '0;
               zi    <= '0;
               iter  <= '0;
               esc_q <= 1'b0;
            end
            S_ITER: begin
               // Escape wins over the cap; z and iter freeze for the result.
               if (escape) begin
                  esc_q <= 1'b1;
               end else if (!iter_at_max) begin
                  zr   <= zr_next;
                  zi   <= zi_next;
                  iter <= iter + ITER_W'(1);
               end
            end
            S_EMIT: begin
               if (out_ready && !last_pix) begin
                  if (col_last) begin
                     col    <= '0;
                     cr_pix <= cr_start_q;
                     row    <= row + DIM_W'(1);
                     ci_pix <= ci_pix + ci_step_q;
                  end else begin
                     col    <= col + DIM_W'(1);
                     cr_pix <= cr_pix + cr_step_q;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Result fields come straight from the frozen pixel state while in EMIT.
   assign out_iterations = iter;
   assign out_escaped    = esc_q;
   assign out_col        = col;
   assign out_row        = row;
   assign out_zr         = zr;
   assign out_zi         = zi;

endmodule

// File: doc/mandel_scan_iterator.md
MANDEL_SCAN_ITERATOR -- requirements
Module: mandel_scan_iterator

Interface
REQ-001 Parameters SHALL be:
- W, 27, fixed-point data width
- FRAC, 23, fraction bits
- ITER_W, 32, iteration counter width
- DIM_W, 10, row/column counter width
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a scan
- cr_start, ci_start  in  W  signed c of pixel (0,0)
- cr_step, ci_step  in  W  signed per-column / per-row c increment
- num_cols, num_rows  in  DIM_W  grid size
- max_iterations  in  ITER_W  per-pixel iteration cap
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_iterations  out  ITER_W  iteration count of pixel
- out_escaped  out  1  1 = escaped, 0 = hit cap
- out_col, out_row  out  DIM_W  pixel coordinates
- out_zr, out_zi  out  W  final z
- busy  out  1  scan in progress
- all_done  out  1  scan complete

Function
REQ-003 FSM states SHALL be IDLE, LOAD, ITER, EMIT, DONE.
REQ-004 Operands SHALL be captured on start in IDLE or DONE; start in any other state SHALL be ignored.
REQ-005 If num_cols==0 or num_rows==0, start SHALL go directly to DONE and emit no results.
REQ-006 LOAD SHALL take 1 cycle: zr=zi=0, iter=0, c = current pixel c.
REQ-007 Each ITER cycle SHALL first test escape on the current z: escape = zr*zr + zi*zi > 4.0, computed at full 2W+1 precision.
REQ-008 On escape or iter==max_iterations, ITER SHALL go to EMIT with out_iterations=iter and out_escaped=escape; escape takes priority when both hold.
REQ-009 Otherwise ITER SHALL apply zr'=zr^2-zi^2+cr and zi'=2*zr*zi+ci, then set iter=iter+1.
REQ-010 Products SHALL be arithmetically shifted right by FRAC and truncated to W; sums SHALL wrap modulo 2^W. Results are defined only for |c|<4.
REQ-011 max_iterations==0 SHALL emit iterations=0 with escaped=0 after exactly one ITER cycle.
REQ-012 Latency from LOAD to out_valid SHALL be iter+2 cycles for a pixel finishing at count iter.
REQ-013 In EMIT, out_valid=1 and all out_* SHALL stay stable until out_valid&&out_ready; the handshake completes in that same cycle.
REQ-014 After a handshake the scan SHALL advance:
- cr += cr_step, col++
- at col==num_cols-1: col=0, cr=cr_start, ci += ci_step, row++
REQ-015 Scan order SHALL be row-major, starting at (0,0).
REQ-016 A handshake on the last pixel SHALL go to DONE; otherwise it SHALL go to LOAD.
REQ-017 busy SHALL be 1 in LOAD, ITER and EMIT.
REQ-018 all_done SHALL be 1 only in DONE and SHALL remain 1 until an accepted start.

Reset
REQ-019 Reset assertion SHALL take effect immediately and asynchronously, including mid-scan.
REQ-020 Reset SHALL force IDLE and zero every output and register: out_valid=0, busy=0, all_done=0.
REQ-021 No result SHALL be produced after reset until a new start.

Structure
REQ-022 Package mandel_pkg SHALL hold the state enum, default W/FRAC/ITER_W, and the fixed-point constant FOUR (4.0 at FRAC).
REQ-023 Sub-module mandel_step SHALL be purely combinational: inputs z, c; outputs next z and escape flag. All state SHALL remain in the parent.

Verification (W=27, FRAC=23, 1.0=0x800000)
REQ-024 Single pixel, c=(0,0), max=100 -> one result: iterations=100, escaped=0, zr=zi=0.
REQ-025 Single pixel, c=(1.0,0), max=100 -> iterations=3, escaped=1, zr=5.0.
REQ-026 Single pixel, c=(0,1.0), max=50 -> iterations=50, escaped=0.
REQ-027 2x2 grid, cr_start=ci_start=0, cr_step=ci_step=1.0, out_ready held 0 for 5 cycles per result -> order (0,0),(1,0),(0,1),(1,1); outputs stable while stalled; all_done after the 4th handshake.
REQ-028 Reset asserted during ITER of a 4x4 scan, then new 1x1 start -> out_valid=0 immediately; exactly one fresh result; num_cols=0 start -> all_done next cycle, no out_valid.
